// File: rtl/rd_req_fifo.sv
// Read-request address buffer for one crossbar slave port: captures acked read addresses
// in order and presents them downstream over valid/ready, driving fifo_full back to the ack controller.
module rd_req_fifo #(
  parameter int unsigned AWIDTH = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       req,
  input  logic                       cmd,
  input  logic [AWIDTH-1:0]          addr,
  input  logic                       ack,
  output logic                       fifo_full,
  output logic [AWIDTH-1:0]          m_addr,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [AWIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              ack_d_q;
  logic              overflow_q, overflow_d;

  logic push_req;
  logic push_acc;
  logic pop;

  assign fifo_full = (count_q == CntW'(DEPTH));
  assign m_valid   = (count_q != '0);
  // Gate with m_valid so the head reads as zero after reset instead of stale storage.
  assign m_addr    = m_valid ? mem[rd_ptr_q] : '0;
  assign count     = count_q;
  assign overflow  = overflow_q;

  // Only the rising edge of ack during a read counts, so a held ack pushes once.
  assign push_req = ack & ~ack_d_q & req & ~cmd;
  assign pop      = m_valid & m_ready;
  assign push_acc = push_req & (~fifo_full | pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_acc) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (push_acc && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!push_acc && pop) begin
      count_d = count_q - CntW'(1);
    end
    if (push_req && fifo_full && !pop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ack_d_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ack_d_q    <= ack;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge aclk) begin
    if (push_acc) begin
      mem[wr_ptr_q] <= addr;
    end
  end

endmodule

// File: tb/tb_rd_req_fifo.sv
// Self-checking bench for rd_req_fifo: directed stimulus queues expected addresses,
// a negedge monitor compares every popped head against the queue.
module tb_rd_req_fifo;

  localparam int unsigned AW    = 32;
  localparam int unsigned DEPTH = 4;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          req = 1'b0;
  logic          cmd = 1'b0;
  logic [AW-1:0] addr = '0;
  logic          ack = 1'b0;
  logic          m_ready = 1'b0;
  logic          fifo_full;
  logic [AW-1:0] m_addr;
  logic          m_valid;
  logic [2:0]    count;
  logic          overflow;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] sb[$];

  rd_req_fifo #(.AWIDTH(AW), .DEPTH(DEPTH)) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .req      (req),
    .cmd      (cmd),
    .addr     (addr),
    .ack      (ack),
    .fifo_full(fifo_full),
    .m_addr   (m_addr),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .count    (count),
    .overflow (overflow)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  // One acked read, then a gap cycle so ack can fall before the next pulse.
  task automatic read_pulse(input logic [31:0] a, input bit expect_push);
    req = 1'b1; cmd = 1'b0; addr = a; ack = 1'b1;
    if (expect_push) sb.push_back(a);
    cyc();
    ack = 1'b0; req = 1'b0;
    cyc();
  endtask

  task automatic drain(input int n);
    m_ready = 1'b1;
    repeat (n) cyc();
    m_ready = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_m_valid"}, 32'(m_valid), 0);
    check({tag, "_count"}, 32'(count), 0);
    check({tag, "_fifo_full"}, 32'(fifo_full), 0);
    check({tag, "_overflow"}, 32'(overflow), 0);
    check({tag, "_m_addr"}, m_addr, 0);
  endtask

  // Asserts reset between clock edges and checks outputs clear before the next edge.
  task automatic mid_reset();
    ack = 1'b0; req = 1'b0; m_ready = 1'b0;
    #2 aresetn = 1'b0;
    #1 check_all_zero("async_reset");
    sb.delete();
    cyc();
    aresetn = 1'b1;
    cyc();
  endtask

  // Scoreboard monitor: each accepted head must match the oldest expected address.
  always @(negedge aclk) begin
    if (aresetn && m_valid && m_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_pop: got 0x%0h, expected no entry", m_addr);
      end else begin
        check("sb_head", m_addr, sb.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin
    #1 check_all_zero("por");
    cyc();
    aresetn = 1'b1;
    repeat (10) cyc();
    check("idle_m_valid", 32'(m_valid), 0);
    check("idle_count", 32'(count), 0);
    check("idle_full", 32'(fifo_full), 0);

    // Single read: visible the cycle after the ack edge, gone the cycle after the pop.
    req = 1'b1; cmd = 1'b0; addr = 32'h0000_1000; ack = 1'b1;
    sb.push_back(32'h0000_1000);
    cyc();
    ack = 1'b0; req = 1'b0;
    check("single_m_valid", 32'(m_valid), 1);
    check("single_m_addr", m_addr, 32'h0000_1000);
    check("single_count", 32'(count), 1);
    cyc();
    check("single_hold_addr", m_addr, 32'h0000_1000);
    m_ready = 1'b1;
    cyc();
    m_ready = 1'b0;
    check("single_pop_valid", 32'(m_valid), 0);
    check("single_pop_count", 32'(count), 0);

    // Fill then overflow.
    read_pulse(32'h10, 1'b1);
    read_pulse(32'h20, 1'b1);
    read_pulse(32'h30, 1'b1);
    check("fill3_full", 32'(fifo_full), 0);
    read_pulse(32'h40, 1'b1);
    check("fill_count", 32'(count), 4);
    check("fill_full", 32'(fifo_full), 1);
    check("fill_no_ovf", 32'(overflow), 0);
    read_pulse(32'h50, 1'b0);
    check("ovf_count", 32'(count), 4);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_head", m_addr, 32'h10);
    drain(4);
    check("drain_m_valid", 32'(m_valid), 0);
    check("drain_count", 32'(count), 0);
    check("ovf_sticky", 32'(overflow), 1);

    // Async reset with an entry queued discards it.
    read_pulse(32'hAB, 1'b1);
    check("pre_reset_count", 32'(count), 1);
    mid_reset();
    check("post_reset_valid", 32'(m_valid), 0);

    // Full with simultaneous push and pop: accepted, no overflow.
    read_pulse(32'h10, 1'b1);
    read_pulse(32'h20, 1'b1);
    read_pulse(32'h30, 1'b1);
    read_pulse(32'h40, 1'b1);
    req = 1'b1; cmd = 1'b0; addr = 32'h99; ack = 1'b1; m_ready = 1'b1;
    sb.push_back(32'h99);
    cyc();
    ack = 1'b0; req = 1'b0; m_ready = 1'b0;
    check("pp_full_count", 32'(count), 4);
    check("pp_full_flag", 32'(fifo_full), 1);
    check("pp_full_no_ovf", 32'(overflow), 0);
    check("pp_full_head", m_addr, 32'h20);
    cyc();
    drain(4);
    check("pp_drain_valid", 32'(m_valid), 0);

    // Write acks never push.
    repeat (3) begin
      req = 1'b1; cmd = 1'b1; addr = 32'hDEAD; ack = 1'b1;
      cyc();
      ack = 1'b0; req = 1'b0;
      cyc();
    end
    check("write_count", 32'(count), 0);
    check("write_m_valid", 32'(m_valid), 0);

    // Held ack pushes exactly once.
    req = 1'b1; cmd = 1'b0; addr = 32'h77; ack = 1'b1;
    sb.push_back(32'h77);
    repeat (5) cyc();
    ack = 1'b0; req = 1'b0;
    cyc();
    check("held_ack_count", 32'(count), 1);
    drain(1);
    check("held_ack_drained", 32'(count), 0);

    // Wrap-around: each push after the first coincides with popping the previous entry.
    for (int i = 1; i <= 10; i++) begin
      req = 1'b1; cmd = 1'b0; addr = 32'(i); ack = 1'b1; m_ready = (i > 1);
      sb.push_back(32'(i));
      cyc();
      check("wrap_count_le2", 32'(count <= 3'd2), 1);
      check("wrap_head", m_addr, 32'(i));
      ack = 1'b0; req = 1'b0; m_ready = 1'b0;
      cyc();
    end
    drain(1);
    check("wrap_end_count", 32'(count), 0);
    check("wrap_no_ovf", 32'(overflow), 0);

    cyc();
    check("sb_drained", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
